// File: rtl/nor_arbiter.sv
// nor_arbiter: round-robin arbiter sharing one registered NOR-only logic unit among N requesters.
// Define NOR_ARB_PRIO_EN to give requester 0 strict priority over the round-robin group.
module nor_arbiter #(
  parameter int N   = 4,
  parameter int W   = 1,
  parameter int IDW = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   a,
  input  logic [N*W-1:0]   b,
  input  logic [2*N-1:0]   op,
  output logic [N-1:0]     gnt,
  output logic [W-1:0]     s,
  output logic [IDW-1:0]   s_id,
  output logic             s_valid,
  input  logic             s_ready
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0]  ptr_q, ptr_d;
  logic [W-1:0]   s_q, s_d;
  logic [IDW-1:0] s_id_q, s_id_d;
  logic           s_valid_q, s_valid_d;

  logic           stall, found, grant_en;
  logic [PW-1:0]  pick, scan;
  logic [N-1:0]   cand;
  logic [W-1:0]   op_a, op_b;
  logic [1:0]     op_sel;
  logic [W-1:0]   f_nor, f_or, f_and, f_nand, f_out;

  // One 2-input NOR cell, applied bitwise; every unit function is a network of these.
  function automatic logic [W-1:0] nor2(input logic [W-1:0] x, input logic [W-1:0] y);
    return ~(x | y);
  endfunction

  // NOTE: every variable gets a default before any conditional write so no latch is inferred.
  always_comb begin
    cand  = req;
    found = 1'b0;
    pick  = '0;
    scan  = '0;
`ifdef NOR_ARB_PRIO_EN
    found   = req[0];
    cand[0] = 1'b0;
`endif
    for (int i = 0; i < N; i++) begin
      scan = PW'((int'(ptr_q) + i) % N);
      if (!found && cand[scan]) begin
        found = 1'b1;
        pick  = scan;
      end
    end
  end

  assign stall    = s_valid_q && !s_ready;
  assign grant_en = found && !stall && rst_n;
  assign gnt      = grant_en ? (N'(1) << pick) : '0;

  always_comb begin
    op_a   = '0;
    op_b   = '0;
    op_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (pick == PW'(i)) begin
        op_a   = a[i*W +: W];
        op_b   = b[i*W +: W];
        op_sel = op[2*i +: 2];
      end
    end
  end

  // OR, AND and NAND are derived by feeding NOR outputs back into further NOR cells.
  assign f_nor  = nor2(op_a, op_b);
  assign f_or   = nor2(f_nor, f_nor);
  assign f_and  = nor2(nor2(op_a, op_a), nor2(op_b, op_b));
  assign f_nand = nor2(f_and, f_and);

  always_comb begin
    unique case (op_sel)
      2'b00:   f_out = f_nor;
      2'b01:   f_out = f_or;
      2'b10:   f_out = f_and;
      default: f_out = f_nand;
    endcase
  end

  always_comb begin
    ptr_d     = ptr_q;
    s_d       = s_q;
    s_id_d    = s_id_q;
    s_valid_d = s_valid_q;
    if (grant_en) begin
      s_d       = f_out;
      s_id_d    = IDW'(pick);
      s_valid_d = 1'b1;
`ifdef NOR_ARB_PRIO_EN
      // Priority grants to requester 0 leave the round-robin position untouched.
      if (pick != '0)
        ptr_d = (int'(pick) == N - 1) ? '0 : pick + 1'b1;
`else
      ptr_d = (int'(pick) == N - 1) ? '0 : pick + 1'b1;
`endif
    end else if (s_valid_q && s_ready) begin
      s_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      s_q       <= '0;
      s_id_q    <= '0;
      s_valid_q <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      s_q       <= s_d;
      s_id_q    <= s_id_d;
      s_valid_q <= s_valid_d;
    end
  end

  assign s       = s_q;
  assign s_id    = s_id_q;
  assign s_valid = s_valid_q;

endmodule

// File: tb/tb_nor_arbiter.sv
// tb_nor_arbiter: truth-table vectors, hand-written corner sequences and random traffic
// against an arbitration/result model for nor_arbiter (honours NOR_ARB_PRIO_EN).
module tb_nor_arbiter;

  localparam int N   = 4;
  localparam int W   = 1;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req;
  logic [N*W-1:0]   a, b;
  logic [2*N-1:0]   op;
  logic [N-1:0]     gnt;
  logic [W-1:0]     s;
  logic [IDW-1:0]   s_id;
  logic             s_valid;
  logic             s_ready;

  int checks = 0;
  int errors = 0;

  // Model state: what the result port and round-robin position should be.
  int         m_ptr;
  logic [W-1:0] m_s;
  int         m_id;
  logic       m_valid;
  logic [N-1:0] obs_gnt;

  typedef struct {
    int         k;
    logic       av;
    logic       bv;
    logic [1:0] opv;
    logic       exp_s;
  } vec_t;

  vec_t tbl[18];

  nor_arbiter #(.N(N), .W(W), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a(a), .b(b), .op(op),
    .gnt(gnt), .s(s), .s_id(s_id), .s_valid(s_valid), .s_ready(s_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_f(input logic [1:0] o, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    case (o)
      2'd0:    return ~(x | y);
      2'd1:    return x | y;
      2'd2:    return x & y;
      default: return ~(x & y);
    endcase
  endfunction

  // Which requester the rules select, or -1 for none.
  function automatic int model_pick(input logic [N-1:0] r, input int p);
    logic [N-1:0] rr;
    rr = r;
`ifdef NOR_ARB_PRIO_EN
    if (rr[0]) return 0;
    rr[0] = 1'b0;
`endif
    for (int i = 0; i < N; i++)
      if (rr[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr   = 0;
    m_s     = '0;
    m_id    = 0;
    m_valid = 1'b0;
  endtask

  // One clock cycle: drive at the falling edge, check gnt, clock, check the result port.
  task automatic cycle(input logic [N-1:0] r, input logic [N*W-1:0] av, input logic [N*W-1:0] bv,
                       input logic [2*N-1:0] o, input logic rdy);
    int pk;
    logic [N-1:0] eg;
    req = r; a = av; b = bv; op = o; s_ready = rdy;
    #1;
    pk = (m_valid && !rdy) ? -1 : model_pick(r, m_ptr);
    eg = (pk >= 0) ? N'(1) << pk : '0;
    obs_gnt = gnt;
    check("gnt", gnt, eg);
    @(posedge clk);
    if (pk >= 0) begin
      m_s     = ref_f(o[2*pk +: 2], av[pk*W +: W], bv[pk*W +: W]);
      m_id    = pk;
      m_valid = 1'b1;
`ifdef NOR_ARB_PRIO_EN
      if (pk != 0) m_ptr = (pk + 1) % N;
`else
      m_ptr = (pk + 1) % N;
`endif
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    #1;
    check("s_valid", s_valid, m_valid);
    check("s", s, m_s);
    check("s_id", s_id, m_id);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{0, 1'b0, 1'b0, 2'b00, 1'b1};
    tbl[1]  = '{0, 1'b1, 1'b0, 2'b00, 1'b0};
    tbl[2]  = '{2, 1'b0, 1'b0, 2'b00, 1'b1};
    tbl[3]  = '{2, 1'b0, 1'b1, 2'b00, 1'b0};
    tbl[4]  = '{2, 1'b1, 1'b0, 2'b00, 1'b0};
    tbl[5]  = '{2, 1'b1, 1'b1, 2'b00, 1'b0};
    tbl[6]  = '{2, 1'b0, 1'b0, 2'b01, 1'b0};
    tbl[7]  = '{2, 1'b0, 1'b1, 2'b01, 1'b1};
    tbl[8]  = '{2, 1'b1, 1'b0, 2'b01, 1'b1};
    tbl[9]  = '{2, 1'b1, 1'b1, 2'b01, 1'b1};
    tbl[10] = '{2, 1'b0, 1'b0, 2'b10, 1'b0};
    tbl[11] = '{2, 1'b0, 1'b1, 2'b10, 1'b0};
    tbl[12] = '{2, 1'b1, 1'b0, 2'b10, 1'b0};
    tbl[13] = '{2, 1'b1, 1'b1, 2'b10, 1'b1};
    tbl[14] = '{2, 1'b0, 1'b0, 2'b11, 1'b1};
    tbl[15] = '{2, 1'b0, 1'b1, 2'b11, 1'b1};
    tbl[16] = '{2, 1'b1, 1'b0, 2'b11, 1'b1};
    tbl[17] = '{2, 1'b1, 1'b1, 2'b11, 1'b0};

    // Reset state with every requester asking: nothing may be granted while rst_n is low.
    rst_n = 1'b0; req = '1; a = '0; b = '0; op = '0; s_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_gnt", gnt, 4'b0000);
    check("rst_s_valid", s_valid, 1'b0);
    check("rst_s", s, 1'b0);
    check("rst_s_id", s_id, 2'd0);
    rst_n = 1'b1;

    for (int t = 0; t < 18; t++) begin
      cycle(N'(1) << tbl[t].k, (N*W)'(tbl[t].av) << tbl[t].k, (N*W)'(tbl[t].bv) << tbl[t].k,
            (2*N)'(tbl[t].opv) << (2 * tbl[t].k), 1'b1);
      check($sformatf("tbl%0d_gnt", t), obs_gnt, N'(1) << tbl[t].k);
      check($sformatf("tbl%0d_s", t), s, tbl[t].exp_s);
      check($sformatf("tbl%0d_s_id", t), s_id, tbl[t].k);
      check($sformatf("tbl%0d_s_valid", t), s_valid, 1'b1);
    end

`ifdef NOR_ARB_PRIO_EN
    do_reset();
    for (int c = 0; c < 4; c++) begin
      cycle(4'b0111, '0, '0, '0, 1'b1);
      check("prio_gnt0", obs_gnt, 4'b0001);
    end
    for (int c = 0; c < 4; c++) begin
      cycle(4'b0110, '0, '0, '0, 1'b1);
      check("prio_rr_gnt", obs_gnt, (c % 2 == 0) ? 4'b0010 : 4'b0100);
    end
`else
    // Fairness: all requesting, grant order 0,1,2,3 repeating; s_id trails by one edge.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      cycle(4'b1111, '0, '0, '0, 1'b1);
      check("rr_gnt", obs_gnt, N'(1) << (c % N));
      check("rr_s_id", s_id, c % N);
    end
`endif

    // Backpressure: a held result blocks requester 1 until the consumer accepts.
    cycle(4'b0001, '0, '0, '0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      cycle(4'b0010, 4'b0010, 4'b0000, 8'b0000_1000, 1'b0);
      check("bp_gnt", obs_gnt, 4'b0000);
      check("bp_s", s, 1'b1);
      check("bp_s_id", s_id, 2'd0);
      check("bp_s_valid", s_valid, 1'b1);
    end
    cycle(4'b0010, 4'b0010, 4'b0000, 8'b0000_1000, 1'b1);
    check("bp_release_gnt", obs_gnt, 4'b0010);
    check("bp_release_s", s, 1'b0);
    check("bp_release_s_id", s_id, 2'd1);

    // Asynchronous reset mid-cycle while a result is valid.
    cycle(4'b0100, '0, '0, '0, 1'b1);
    req = 4'b1111;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_s_valid", s_valid, 1'b0);
    check("arst_s", s, 1'b0);
    check("arst_s_id", s_id, 2'd0);
    check("arst_gnt", gnt, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(4'b1010, '0, '0, '0, 1'b1);
    check("arst_first_gnt", obs_gnt, 4'b0010);

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      cycle(N'($urandom), (N*W)'($urandom), (N*W)'($urandom), (2*N)'($urandom),
            ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
